// File: rtl/dcache_controller_pkg.sv
// Shared constants and FSM encodings for the
// direct-mapped write-through data cache.
package dcache_controller_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'd0,
    DC_FILL  = 2'd1,
    DC_WRITE = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational read,
// synchronous word write, async-clear valid bits.
module dcache_array #(
  parameter int W     = 32,
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int TW    = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] i_ridx,
  input  logic [$clog2(WPL)-1:0]   i_roff,
  output logic                     o_valid,
  output logic [TW-1:0]            o_tag,
  output logic [W-1:0]             o_data,
  input  logic [$clog2(LINES)-1:0] i_widx,
  input  logic [$clog2(WPL)-1:0]   i_woff,
  input  logic                     i_we,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_tag_we,
  input  logic [TW-1:0]            i_wtag,
  input  logic                     i_inval
);

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [W-1:0]     r_data [LINES][WPL];

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx][i_roff];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else begin
      if (i_inval)  r_valid[i_widx] <= 1'b0;
      if (i_tag_we) r_valid[i_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we)     r_data[i_widx][i_woff] <= i_wdata;
    if (i_tag_we) r_tag[i_widx] <= i_wtag;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate
// data cache with a multi-cycle memory handshake.
module dcache_controller
  import dcache_controller_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [WORD_SIZE-1:0] AddrM,
  input  logic [WORD_SIZE-1:0] WriteDataM,
  output logic [WORD_SIZE-1:0] ReadDataM,
  output logic                 StallMemM,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int TW = WORD_SIZE - IB - OB - 2;

  dc_state_e            r_state, w_state_n;
  logic                 r_req, w_req_n;
  logic                 r_we, w_we_n;
  logic [WORD_SIZE-1:0] r_addr, w_addr_n;
  logic [WORD_SIZE-1:0] r_wdata, w_wdata_n;
  logic [OB-1:0]        r_cnt, w_cnt_n;
  logic                 r_done, w_done_n;

  logic [OB-1:0]        w_a_off, w_r_off;
  logic [IB-1:0]        w_a_idx, w_r_idx;
  logic [TW-1:0]        w_a_tag, w_r_tag;
  logic                 w_unused;

  logic                 w_valid, w_hit, w_ack;
  logic [TW-1:0]        w_tag;
  logic [WORD_SIZE-1:0] w_data;

  logic                 w_arr_we, w_tag_we, w_inval;
  logic [IB-1:0]        w_arr_idx;
  logic [OB-1:0]        w_arr_off;
  logic [WORD_SIZE-1:0] w_arr_wdata;
  logic [TW-1:0]        w_arr_tag;

  assign w_a_off  = AddrM[OB+1:2];
  assign w_a_idx  = AddrM[IB+OB+1:OB+2];
  assign w_a_tag  = AddrM[WORD_SIZE-1:IB+OB+2];
  assign w_r_off  = r_addr[OB+1:2];
  assign w_r_idx  = r_addr[IB+OB+1:OB+2];
  assign w_r_tag  = r_addr[WORD_SIZE-1:IB+OB+2];
  assign w_unused = ^{AddrM[1:0], w_r_off};

  dcache_array #(
    .W     (WORD_SIZE),
    .LINES (LINES),
    .WPL   (WORDS_PER_LINE),
    .TW    (TW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .i_ridx   (w_a_idx),
    .i_roff   (w_a_off),
    .o_valid  (w_valid),
    .o_tag    (w_tag),
    .o_data   (w_data),
    .i_widx   (w_arr_idx),
    .i_woff   (w_arr_off),
    .i_we     (w_arr_we),
    .i_wdata  (w_arr_wdata),
    .i_tag_we (w_tag_we),
    .i_wtag   (w_arr_tag),
    .i_inval  (w_inval)
  );

  assign w_hit = w_valid && (w_tag == w_a_tag);
  assign w_ack = mem_ack && r_req;

  // r_done masks the still-held request for one cycle after a store
  assign StallMemM = (r_state != DC_IDLE) ||
                     (!r_done && ((MemReadM && !w_hit) || MemWriteM));
  assign ReadDataM = (MemReadM && !MemWriteM && w_hit) ? w_data : '0;

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_comb begin
    w_state_n   = r_state;
    w_req_n     = r_req;
    w_we_n      = r_we;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_cnt_n     = r_cnt;
    w_done_n    = 1'b0;
    w_arr_we    = 1'b0;
    w_tag_we    = 1'b0;
    w_inval     = 1'b0;
    w_arr_idx   = w_a_idx;
    w_arr_off   = w_a_off;
    w_arr_wdata = WriteDataM;
    w_arr_tag   = w_r_tag;
    unique case (r_state)
      DC_IDLE: begin
        if (!r_done && MemWriteM) begin
          w_state_n = DC_WRITE;
          w_req_n   = 1'b1;
          w_we_n    = 1'b1;
          w_addr_n  = {AddrM[WORD_SIZE-1:2], 2'b00};
          w_wdata_n = WriteDataM;
          w_arr_we  = w_hit;
        end else if (!r_done && MemReadM && !w_hit) begin
          w_state_n = DC_FILL;
          w_req_n   = 1'b1;
          w_we_n    = 1'b0;
          w_cnt_n   = '0;
          w_addr_n  = {w_a_tag, w_a_idx, {OB{1'b0}}, 2'b00};
          w_inval   = 1'b1;
        end
      end
      DC_FILL: begin
        w_arr_idx   = w_r_idx;
        w_arr_off   = r_cnt;
        w_arr_wdata = mem_rdata;
        if (w_ack) begin
          w_arr_we = 1'b1;
          w_cnt_n  = r_cnt + 1'b1;
          w_req_n  = 1'b0;
          if (r_cnt == OB'(WORDS_PER_LINE - 1)) begin
            w_tag_we  = 1'b1;
            w_state_n = DC_IDLE;
          end
        end else if (!r_req) begin
          w_req_n  = 1'b1;
          w_addr_n = {w_r_tag, w_r_idx, r_cnt, 2'b00};
        end
      end
      DC_WRITE: begin
        if (w_ack) begin
          w_req_n   = 1'b0;
          w_we_n    = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = DC_IDLE;
        end
      end
      default: w_state_n = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DC_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_done_n;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench with a request scoreboard and
// a 3-cycle-latency main-memory model.
module tb_dcache_controller;

  localparam int DELAY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] AddrM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallMemM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        sb[$];
  logic [31:0] wmem [logic [31:0]];
  int          nvec = 0;
  int          nfail = 0;
  int          nack = 0;
  int          mcnt = 0;

  dcache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMemM  (StallMemM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memrd(logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      req_t r;
      r.we = 1'b0;
      r.addr = base + 32'(4 * i);
      r.wdata = '0;
      sb.push_back(r);
    end
  endtask

  task automatic push_wr(logic [31:0] a, logic [31:0] d);
    req_t r;
    r.we = 1'b1;
    r.addr = a;
    r.wdata = d;
    sb.push_back(r);
  endtask

  task automatic drive(logic rd, logic wr, logic [31:0] a,
                       logic [31:0] d);
    @(posedge clk);
    #2;
    MemReadM = rd;
    MemWriteM = wr;
    AddrM = a;
    WriteDataM = d;
    #1;
  endtask

  task automatic wait_nostall(output int cyc);
    cyc = 0;
    while (StallMemM === 1'b1 && cyc < 200) begin
      @(posedge clk);
      #3;
      cyc++;
    end
    chk("stall_bound", 32'(cyc < 200), 32'd1);
  endtask

  // Memory model: acks DELAY cycles into each request
  always @(negedge clk) begin
    if (!rst) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      mcnt++;
      if (mcnt == DELAY) begin
        mcnt = 0;
        if (sb.size() == 0) begin
          chk("unexpected_req", mem_addr, 32'hFFFF_FFFF);
        end else begin
          req_t e;
          e = sb.pop_front();
          chk("req_we", 32'(mem_we), 32'(e.we));
          chk("req_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("req_wdata", mem_wdata, e.wdata);
            wmem[e.addr] = e.wdata;
          end
        end
        mem_rdata = memrd(mem_addr);
        mem_ack = 1'b1;
        nack++;
      end
    end
  end

  initial begin
    int cyc;
    int base;
    #3;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_stall", 32'(StallMemM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    push_rd(32'h100);
    drive(1, 0, 32'h100, 0);
    chk("t1_stall", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t1_data", ReadDataM, memrd(32'h100));
    chk("t1_beats", 32'(sb.size()), 32'd0);
    chk("t1_cycles", 32'(cyc >= 12 && cyc <= 20), 32'd1);

    drive(1, 0, 32'h108, 0);
    chk("t2_stall", 32'(StallMemM), 32'd0);
    chk("t2_data", ReadDataM, memrd(32'h108));
    chk("t2_req", 32'(mem_req), 32'd0);

    push_wr(32'h104, 32'hDEADBEEF);
    drive(0, 1, 32'h104, 32'hDEADBEEF);
    chk("t3_stall", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t3_writes", 32'(sb.size()), 32'd0);
    drive(1, 0, 32'h104, 0);
    chk("t3_hit_stall", 32'(StallMemM), 32'd0);
    chk("t3_hit_data", ReadDataM, 32'hDEADBEEF);

    push_wr(32'h900, 32'h12345678);
    drive(0, 1, 32'h900, 32'h12345678);
    chk("t4_stall", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t4_writes", 32'(sb.size()), 32'd0);
    drive(1, 0, 32'h100, 0);
    chk("t4_hit100", 32'(StallMemM), 32'd0);
    chk("t4_data100", ReadDataM, memrd(32'h100));
    push_rd(32'h900);
    drive(1, 0, 32'h900, 0);
    chk("t4_miss900", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t4_data900", ReadDataM, 32'h12345678);
    chk("t4_beats", 32'(sb.size()), 32'd0);

    push_rd(32'h100);
    base = nack;
    drive(1, 0, 32'h100, 0);
    chk("t5_miss", 32'(StallMemM), 32'd1);
    cyc = 0;
    while (!(nack == base + 1 && mem_req) && cyc < 100) begin
      @(posedge clk);
      #3;
      cyc++;
    end
    chk("t5_beat2", 32'(cyc < 100), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_req_drop", 32'(mem_req), 32'd0);
    MemReadM = 1'b0;
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    push_rd(32'h100);
    drive(1, 0, 32'h100, 0);
    chk("t5_remiss", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t5_data", ReadDataM, memrd(32'h100));

    push_wr(32'h200, 32'hCAFEF00D);
    drive(1, 1, 32'h200, 32'hCAFEF00D);
    chk("t6_stall", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t6_writes", 32'(sb.size()), 32'd0);
    chk("t6_rdata", ReadDataM, 32'd0);
    drive(0, 0, 32'h200, 0);
    push_rd(32'h200);
    drive(1, 0, 32'h200, 0);
    chk("t6_not_valid", 32'(StallMemM), 32'd1);
    wait_nostall(cyc);
    chk("t6_data", ReadDataM, 32'hCAFEF00D);
    chk("t6_beats", 32'(sb.size()), 32'd0);
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
